// File: rtl/counter_cmd_pkg.sv
// Shared types for the counter command sequencer: command opcodes, FSM states,
// the default load clamp and the clamp helper.
package counter_cmd_pkg;

    localparam int unsigned MAX_LOAD_DEF = 4;
    localparam int unsigned LOAD_W       = 4;

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_LOAD      = 2'b01,
        OP_STEP_UP   = 2'b10,
        OP_STEP_DOWN = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_STEP = 2'b10,
        ST_DONE = 2'b11
    } seq_state_e;

    function automatic logic [LOAD_W-1:0] clamp_load(input int unsigned arg,
                                                     input int unsigned max_v);
        return (arg > max_v) ? LOAD_W'(max_v) : LOAD_W'(arg);
    endfunction

endpackage

// File: rtl/counter_cmd_seq_step_count.sv
// Loadable down-counter holding the remaining STEP cycles; saturates at zero.
module step_count #(
    parameter int ARG_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [ARG_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [ARG_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - ARG_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/counter_cmd_seq.sv
// Command sequencer driving a downstream counter: LOAD, STEP_UP/DOWN by N, NOP,
// with abort. Every output but o_cmd_ready comes straight from a flop.
module counter_cmd_seq
    import counter_cmd_pkg::*;
#(
    parameter int unsigned MAX_LOAD = MAX_LOAD_DEF,
    parameter int          ARG_W    = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [1:0]        i_cmd_op,
    input  logic [ARG_W-1:0]  i_cmd_arg,
    input  logic              i_abort,
    output logic              o_enable,
    output logic              o_up,
    output logic              o_load,
    output logic [LOAD_W-1:0] o_load_signal,
    output logic              o_done,
    output logic              o_err
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_LOAD = ST_LOAD;
    localparam logic [1:0] S_STEP = ST_STEP;
    localparam logic [1:0] S_DONE = ST_DONE;

    logic [1:0]        r_state;
    logic              r_enable;
    logic              r_up;
    logic              r_load;
    logic [LOAD_W-1:0] r_load_signal;
    logic              r_done;
    logic              r_err;

    cmd_op_e w_op;
    logic    w_accept;
    logic    w_is_step;
    logic    w_arg_zero;
    logic    w_cnt_load;
    logic    w_cnt_dec;
    logic    w_last;

    assign w_op       = cmd_op_e'(i_cmd_op);
    assign o_cmd_ready = (r_state == S_IDLE) && !i_reset;
    assign w_accept   = i_cmd_valid && o_cmd_ready;
    assign w_is_step  = (w_op == OP_STEP_UP) || (w_op == OP_STEP_DOWN);
    assign w_arg_zero = (i_cmd_arg == '0);

    // Counter holds remaining cycles after the current one, so zero marks the last enable cycle.
    assign w_cnt_load = w_accept && w_is_step && !w_arg_zero;
    assign w_cnt_dec  = (r_state == S_STEP) && !w_last;

    step_count #(
        .ARG_W (ARG_W)
    ) u_step_count (
        .i_clk      (i_clk),
        .i_rst      (i_reset),
        .i_load     (w_cnt_load),
        .i_load_val (i_cmd_arg - ARG_W'(1)),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_last)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_enable      <= 1'b0;
            r_up          <= 1'b0;
            r_load        <= 1'b0;
            r_load_signal <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_enable <= 1'b0;
            r_load   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (w_op)
                            OP_LOAD: begin
                                r_state       <= S_LOAD;
                                r_load        <= 1'b1;
                                r_load_signal <= clamp_load(32'(i_cmd_arg), MAX_LOAD);
                                r_err         <= (32'(i_cmd_arg) > MAX_LOAD);
                            end
                            OP_STEP_UP, OP_STEP_DOWN: begin
                                if (w_arg_zero) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state  <= S_STEP;
                                    r_enable <= 1'b1;
                                    r_up     <= (w_op == OP_STEP_UP);
                                end
                            end
                            default: begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end
                S_STEP: begin
                    // Abort on the final cycle lands here too, so it completes normally.
                    if (w_last || i_abort) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_enable <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_enable      = r_enable;
    assign o_up          = r_up;
    assign o_load        = r_load;
    assign o_load_signal = r_load_signal;
    assign o_done        = r_done;
    assign o_err         = r_err;

endmodule

// File: doc/counter_cmd_seq.md
COUNTER_CMD_SEQ -- requirements
Module: counter_cmd_seq

Interface
REQ-001 Parameter MAX_LOAD, default 4: largest value driven on load_signal.
REQ-002 Parameter ARG_W, default 4: width of cmd_arg and of the step count.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  sequencer can accept a command.
REQ-007 cmd_op  in  2  00 NOP, 01 LOAD, 10 STEP_UP, 11 STEP_DOWN.
REQ-008 cmd_arg  in  ARG_W  load value (LOAD) or step count (STEP_*).
REQ-009 abort  in  1  terminate the current command early.
REQ-010 enable  out  1  count-enable strobe to the downstream counter.
REQ-011 up  out  1  count direction to the downstream counter (1 = up).
REQ-012 load  out  1  load strobe to the downstream counter.
REQ-013 load_signal  out  4  value to load.
REQ-014 done  out  1  one-cycle pulse at command completion.
REQ-015 err  out  1  one-cycle pulse, LOAD argument was clamped.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, STEP, DONE.
REQ-017 cmd_ready SHALL be 1 exactly when state is IDLE and reset is low.
REQ-018 A command SHALL be accepted only on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_op and cmd_arg are captured at that edge.
REQ-019 Transitions from IDLE on accept: NOP→DONE; LOAD→LOAD; STEP_* with arg=0→DONE; STEP_* with arg>0→STEP.
REQ-020 LOAD state SHALL last exactly one cycle with load=1 and load_signal=min(arg, MAX_LOAD), then go to DONE.
REQ-021 If a LOAD arg exceeds MAX_LOAD, err SHALL pulse in the same cycle as load=1.
REQ-022 STEP state SHALL assert enable=1 for exactly arg consecutive cycles. up SHALL be 1 for STEP_UP and 0 for STEP_DOWN, constant for the whole command. STEP then goes to DONE.
REQ-023 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-024 Latency, accept at edge N: LOAD/NOP with arg=0 signal done at N+2/N+1; STEP with arg k drives enable in cycles N+1..N+k and done in cycle N+k+1.
REQ-025 load and enable SHALL never both be 1 in the same cycle.
REQ-026 Outside LOAD, load SHALL be 0 and load_signal SHALL hold its last value. Outside STEP, enable SHALL be 0 and up SHALL hold its last value.
REQ-027 abort=1 in LOAD or STEP SHALL deassert load/enable from the next cycle and go to DONE.
REQ-028 If abort coincides with the last enable cycle, the step completes and is counted as normal.
REQ-029 abort in IDLE or DONE SHALL be ignored.
REQ-030 All outputs except cmd_ready SHALL be registered.

Reset
REQ-031 While reset=1: state=IDLE; enable, up, load, done, err, cmd_ready all 0; load_signal=0; step count=0.
REQ-032 Reset asserted mid-command SHALL discard the command with no done pulse.
REQ-033 cmd_ready SHALL rise combinationally once reset falls.

Structure
REQ-034 Package counter_cmd_pkg SHALL hold the op enum, the state enum and the MAX_LOAD default.
REQ-035 The step count SHALL be a sub-module step_count: loadable ARG_W-bit down-counter with a zero flag.

Verification
REQ-036 Reset, then LOAD arg=3 → load=1 with load_signal=3 for one cycle, done one cycle later, err=0.
REQ-037 LOAD arg=9 → load_signal=4 and err=1 in the same cycle.
REQ-038 STEP_UP arg=5 → enable=1 and up=1 for exactly 5 cycles, done in the 6th cycle, cmd_ready=0 throughout.
REQ-039 STEP_DOWN arg=0 → no enable, done the cycle after accept.
REQ-040 STEP_UP arg=6 with abort in the 3rd enable cycle → exactly 3 enable cycles, then done.
REQ-041 Back-to-back cmd_valid held high → the second command is accepted the cycle after done; assert reset during STEP → all outputs 0 immediately and no done pulse.
